// File: rtl/riscv_arb_pkg.sv
// rtl/riscv_arb_pkg.sv - shared types and sizing helpers for the instr/data memory arbiter
package riscv_arb_pkg;

   typedef enum logic {SRC_INSTR, SRC_DATA} arb_src_e;

   // Width needed to hold an occupancy count of 0..max_out inclusive.
   function automatic int cnt_width(input int max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/riscv_arb_idfifo.sv
// rtl/riscv_arb_idfifo.sv - in-order FIFO of transaction sources awaiting a memory response
module riscv_arb_idfifo
   import riscv_arb_pkg::*;
#(
   parameter int MAX_OUT = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  logic     pop,
   input  arb_src_e din,
   output arb_src_e head,
   output logic     full,
   output logic     empty
);

   localparam int CNT_W = cnt_width(MAX_OUT);
   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   arb_src_e         slots [MAX_OUT];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(MAX_OUT));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   // A pop against an empty FIFO is a stray response and is ignored.
   assign do_pop  = pop & ~empty;
   assign head    = slots[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         slots[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - instr/data master arbiter onto one memory port; RISCV_ARB_STARVE_EN adds instr anti-starvation
module riscv_mem_arbiter
   import riscv_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_OUT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_instr_req,
   input  logic [ADDR_W-1:0]   i_instr_addr,
   output logic                o_instr_gnt,
   output logic                o_instr_rvalid,
   output logic [DATA_W-1:0]   o_instr_rdata,
   input  logic                i_data_req,
   input  logic                i_data_we,
   input  logic [DATA_W/8-1:0] i_data_be,
   input  logic [ADDR_W-1:0]   i_data_addr,
   input  logic [DATA_W-1:0]   i_data_wdata,
   output logic                o_data_gnt,
   output logic                o_data_rvalid,
   output logic [DATA_W-1:0]   o_data_rdata,
   output logic                o_mem_req,
   output logic                o_mem_we,
   output logic [DATA_W/8-1:0] o_mem_be,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   input  logic                i_mem_gnt,
   input  logic                i_mem_rvalid,
   input  logic [DATA_W-1:0]   i_mem_rdata
);

   arb_src_e sel;
   arb_src_e head;
   logic     fifo_full;
   logic     fifo_empty;
   logic     xfer;

`ifdef RISCV_ARB_STARVE_EN
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   logic [STARVE_W-1:0] starve_cnt;
   logic                starve_hit;

   assign starve_hit = (starve_cnt == STARVE_W'(STARVE_MAX));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!i_instr_req || o_instr_gnt) begin
         starve_cnt <= '0;
      end else if (!starve_hit) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   logic starve_hit;
   logic unused_starve_cfg;

   assign starve_hit        = 1'b0;
   assign unused_starve_cfg = (STARVE_MAX > 0);
`endif

   always_comb begin
      sel = SRC_INSTR;
      if (i_data_req && !(starve_hit && i_instr_req)) begin
         sel = SRC_DATA;
      end
   end

   assign o_mem_req   = (i_instr_req | i_data_req) & ~fifo_full & rst_n;
   assign xfer        = o_mem_req & i_mem_gnt;
   assign o_instr_gnt = xfer & (sel == SRC_INSTR);
   assign o_data_gnt  = xfer & (sel == SRC_DATA);

   // Fetches are always full-word reads.
   assign o_mem_we    = (sel == SRC_DATA) ? i_data_we    : 1'b0;
   assign o_mem_be    = (sel == SRC_DATA) ? i_data_be    : '1;
   assign o_mem_addr  = (sel == SRC_DATA) ? i_data_addr  : i_instr_addr;
   assign o_mem_wdata = (sel == SRC_DATA) ? i_data_wdata : '0;

   riscv_arb_idfifo #(
      .MAX_OUT (MAX_OUT)
   ) u_idfifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (xfer),
      .pop   (i_mem_rvalid),
      .din   (sel),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign o_instr_rvalid = i_mem_rvalid & ~fifo_empty & rst_n & (head == SRC_INSTR);
   assign o_data_rvalid  = i_mem_rvalid & ~fifo_empty & rst_n & (head == SRC_DATA);
   assign o_instr_rdata  = i_mem_rdata;
   assign o_data_rdata   = i_mem_rdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - scoreboard bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_instr_req;
   logic [31:0] i_instr_addr;
   logic        o_instr_gnt;
   logic        o_instr_rvalid;
   logic [31:0] o_instr_rdata;
   logic        i_data_req;
   logic        i_data_we;
   logic [3:0]  i_data_be;
   logic [31:0] i_data_addr;
   logic [31:0] i_data_wdata;
   logic        o_data_gnt;
   logic        o_data_rvalid;
   logic [31:0] o_data_rdata;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        i_mem_gnt;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;

   int checks = 0;
   int errors = 0;

   // Expected responses: {1 = data master / 0 = instr master, rdata}
   logic [32:0] exp_q [$];

`ifdef RISCV_ARB_STARVE_EN
   logic [7:0] starve_pat = 8'b0001_0000;
`else
   logic [7:0] starve_pat = 8'b0000_0000;
`endif

   always #5 clk = ~clk;

   riscv_mem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .MAX_OUT    (2),
      .STARVE_MAX (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_instr_req    (i_instr_req),
      .i_instr_addr   (i_instr_addr),
      .o_instr_gnt    (o_instr_gnt),
      .o_instr_rvalid (o_instr_rvalid),
      .o_instr_rdata  (o_instr_rdata),
      .i_data_req     (i_data_req),
      .i_data_we      (i_data_we),
      .i_data_be      (i_data_be),
      .i_data_addr    (i_data_addr),
      .i_data_wdata   (i_data_wdata),
      .o_data_gnt     (o_data_gnt),
      .o_data_rvalid  (o_data_rvalid),
      .o_data_rdata   (o_data_rdata),
      .o_mem_req      (o_mem_req),
      .o_mem_we       (o_mem_we),
      .o_mem_be       (o_mem_be),
      .o_mem_addr     (o_mem_addr),
      .o_mem_wdata    (o_mem_wdata),
      .i_mem_gnt      (i_mem_gnt),
      .i_mem_rvalid   (i_mem_rvalid),
      .i_mem_rdata    (i_mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_instr_req  = 1'b0;
      i_instr_addr = '0;
      i_data_req   = 1'b0;
      i_data_we    = 1'b0;
      i_data_be    = '0;
      i_data_addr  = '0;
      i_data_wdata = '0;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
   endtask

   task automatic respond(input logic is_data, input logic [31:0] rdata);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = rdata;
      exp_q.push_back({is_data, rdata});
   endtask

   // Monitor: every response the DUT presents must match the oldest expectation.
   always @(negedge clk) begin
      if (o_instr_rvalid || o_data_rvalid) begin
         logic [32:0] e;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: got instr=%0b data=%0b expected none at %0t",
                     o_instr_rvalid, o_data_rvalid, $time);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_instr_rvalid", {31'd0, o_instr_rvalid}, {31'd0, ~e[32]});
            chk("rsp_data_rvalid",  {31'd0, o_data_rvalid},  {31'd0, e[32]});
            chk("rsp_rdata", e[32] ? o_data_rdata : o_instr_rdata, e[31:0]);
         end
      end
   end

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      i_instr_req = 1'b1;
      i_mem_gnt   = 1'b1;
      @(negedge clk);
      chk("rst_mem_req",   {31'd0, o_mem_req},   32'd0);
      chk("rst_instr_gnt", {31'd0, o_instr_gnt}, 32'd0);
      next_cycle();
      next_cycle();
      idle_inputs();
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_mem_req", {31'd0, o_mem_req}, 32'd0);
      next_cycle();

      // Single fetch with response one cycle later
      i_instr_req  = 1'b1;
      i_instr_addr = 32'h0000_0100;
      i_mem_gnt    = 1'b1;
      @(negedge clk);
      chk("t1_instr_gnt", {31'd0, o_instr_gnt}, 32'd1);
      chk("t1_data_gnt",  {31'd0, o_data_gnt},  32'd0);
      chk("t1_mem_addr",  o_mem_addr,           32'h0000_0100);
      chk("t1_mem_we",    {31'd0, o_mem_we},    32'd0);
      chk("t1_mem_be",    {28'd0, o_mem_be},    32'hf);
      next_cycle();
      idle_inputs();
      respond(1'b0, 32'h0000_0013);
      @(negedge clk);
      chk("t1_data_rvalid", {31'd0, o_data_rvalid}, 32'd0);
      next_cycle();
      idle_inputs();

      // Both masters together: data first, instr next, responses in order
      i_instr_req  = 1'b1;
      i_instr_addr = 32'h0000_0200;
      i_data_req   = 1'b1;
      i_data_we    = 1'b1;
      i_data_be    = 4'b0011;
      i_data_addr  = 32'h0000_8000;
      i_data_wdata = 32'hdead_beef;
      i_mem_gnt    = 1'b1;
      @(negedge clk);
      chk("t2_data_gnt",  {31'd0, o_data_gnt},  32'd1);
      chk("t2_instr_gnt", {31'd0, o_instr_gnt}, 32'd0);
      chk("t2_mem_addr",  o_mem_addr,           32'h0000_8000);
      chk("t2_mem_we",    {31'd0, o_mem_we},    32'd1);
      chk("t2_mem_be",    {28'd0, o_mem_be},    32'h3);
      chk("t2_mem_wdata", o_mem_wdata,          32'hdead_beef);
      next_cycle();
      i_data_req = 1'b0;
      @(negedge clk);
      chk("t2_instr_gnt2", {31'd0, o_instr_gnt}, 32'd1);
      chk("t2_mem_addr2",  o_mem_addr,           32'h0000_0200);
      next_cycle();
      idle_inputs();
      respond(1'b1, 32'haaaa_0001);
      next_cycle();
      respond(1'b0, 32'h5555_0002);
      next_cycle();
      idle_inputs();

      // FIFO full backpressure, no push-through on a same-cycle pop
      i_instr_req  = 1'b1;
      i_instr_addr = 32'h0000_0400;
      i_mem_gnt    = 1'b1;
      @(negedge clk);
      chk("t3_gnt_a", {31'd0, o_instr_gnt}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("t3_gnt_b", {31'd0, o_instr_gnt}, 32'd1);
      next_cycle();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t3_full_req", {31'd0, o_mem_req},   32'd0);
         chk("t3_full_gnt", {31'd0, o_instr_gnt}, 32'd0);
         next_cycle();
      end
      respond(1'b0, 32'h0000_3001);
      @(negedge clk);
      chk("t3_pop_req", {31'd0, o_mem_req}, 32'd0);
      next_cycle();
      i_mem_rvalid = 1'b0;
      @(negedge clk);
      chk("t3_gnt_c", {31'd0, o_instr_gnt}, 32'd1);
      next_cycle();
      idle_inputs();
      respond(1'b0, 32'h0000_3002);
      next_cycle();
      respond(1'b0, 32'h0000_3003);
      next_cycle();
      idle_inputs();

      // Both masters held high; one response per cycle keeps the FIFO from filling
      for (int i = 0; i < 8; i++) begin
         i_instr_req  = 1'b1;
         i_instr_addr = 32'h0000_0600;
         i_data_req   = 1'b1;
         i_data_addr  = 32'h0000_9000;
         i_data_be    = 4'hf;
         i_mem_gnt    = 1'b1;
         if (i > 0) begin
            respond(~starve_pat[i-1], 32'h0000_1000 + 32'(i));
         end
         @(negedge clk);
         chk("t4_instr_gnt", {31'd0, o_instr_gnt}, {31'd0, starve_pat[i]});
         chk("t4_data_gnt",  {31'd0, o_data_gnt},  {31'd0, ~starve_pat[i]});
         next_cycle();
      end
      idle_inputs();
      respond(~starve_pat[7], 32'h0000_1008);
      next_cycle();
      idle_inputs();

      // Reset with two transfers outstanding, then stray responses
      i_instr_req  = 1'b1;
      i_instr_addr = 32'h0000_0700;
      i_mem_gnt    = 1'b1;
      next_cycle();
      next_cycle();
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_rst_req", {31'd0, o_mem_req}, 32'd0);
      next_cycle();
      idle_inputs();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         i_mem_rvalid = 1'b1;
         i_mem_rdata  = 32'hbad0_0000 + 32'(i);
         @(negedge clk);
         chk("t5_stray_instr_rvalid", {31'd0, o_instr_rvalid}, 32'd0);
         chk("t5_stray_data_rvalid",  {31'd0, o_data_rvalid},  32'd0);
         next_cycle();
      end
      idle_inputs();
      i_instr_req  = 1'b1;
      i_instr_addr = 32'h0000_0300;
      i_mem_gnt    = 1'b1;
      @(negedge clk);
      chk("t5_post_gnt", {31'd0, o_instr_gnt}, 32'd1);
      next_cycle();
      idle_inputs();
      respond(1'b0, 32'h0000_0077);
      next_cycle();
      idle_inputs();
      next_cycle();

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
